// File: rtl/bitcount_arbiter_pkg.sv
// Shared constants for the two-requester bit-count arbiter.
// Holds width defaults, FSM encoding and requester ids.
package bitcount_arbiter_pkg;

  localparam int DEF_OPW  = 5;
  localparam int DEF_RESW = 32;
  localparam int DEF_CNTW = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

endpackage

// File: rtl/bitcount_core.sv
// Combinational one-bit-count datapath for two operands.
// Produces the 4-bit sum, its even-parity flag and the extended result.
module bitcount_core
  import bitcount_arbiter_pkg::*;
#(
  parameter int OPW  = DEF_OPW,
  parameter int RESW = DEF_RESW
) (
  input  logic [OPW-1:0]  i_num1,
  input  logic [OPW-1:0]  i_num2,
  output logic [3:0]      o_calc,
  output logic            o_balance,
  output logic [RESW-1:0] o_result
);

  logic [3:0] w_pc1;
  logic [3:0] w_pc2;

  always_comb begin
    w_pc1 = '0;
    w_pc2 = '0;
    for (int i = 0; i < OPW; i++) begin
      w_pc1 = w_pc1 + {3'b000, i_num1[i]};
      w_pc2 = w_pc2 + {3'b000, i_num2[i]};
    end
  end

  assign o_calc    = w_pc1 + w_pc2;
  assign o_balance = ~^o_calc;
  // Writeback expects bit 3 replicated upward
  assign o_result  = {{(RESW-4){o_calc[3]}}, o_calc};

endmodule

// File: rtl/bitcount_arbiter.sv
// Round-robin arbiter sharing one bit-count core between two requesters.
// Captures operands, computes in one cycle, holds a registered response.
module bitcount_arbiter
  import bitcount_arbiter_pkg::*;
#(
  parameter int OPW  = DEF_OPW,
  parameter int RESW = DEF_RESW,
  parameter int CNTW = DEF_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic [OPW-1:0]  num1_0,
  input  logic [OPW-1:0]  num2_0,
  output logic            ack0,
  input  logic            req1,
  input  logic [OPW-1:0]  num1_1,
  input  logic [OPW-1:0]  num2_1,
  output logic            ack1,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [RESW-1:0] resp_result,
  output logic            resp_balance,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  state_t            r_state;
  state_t            w_next;
  logic              r_ptr;
  logic              r_id;
  logic [OPW-1:0]    r_n1;
  logic [OPW-1:0]    r_n2;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_resp_valid;
  logic              r_resp_id;
  logic [RESW-1:0]   r_result;
  logic              r_bal;
  logic [CNTW-1:0]   r_cnt;
  logic              w_gnt0;
  logic              w_gnt1;
  logic [3:0]        w_calc_unused;
  logic              w_bal;
  logic [RESW-1:0]   w_result;

  bitcount_core #(
    .OPW  (OPW),
    .RESW (RESW)
  ) u_core (
    .i_num1    (r_n1),
    .i_num2    (r_n2),
    .o_calc    (w_calc_unused),
    .o_balance (w_bal),
    .o_result  (w_result)
  );

  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // r_ptr names the requester that wins a tie
        w_gnt0 = req0 & (~req1 | (r_ptr == ID0));
        w_gnt1 = req1 & (~req0 | (r_ptr == ID1));
        if (w_gnt0 | w_gnt1) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        if (r_resp_valid && resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= ID0;
      r_id         <= ID0;
      r_n1         <= '0;
      r_n2         <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_result     <= '0;
      r_bal        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_next;
      r_ack0  <= w_gnt0;
      r_ack1  <= w_gnt1;
      if (w_gnt0 | w_gnt1) begin
        r_n1  <= w_gnt1 ? num1_1 : num1_0;
        r_n2  <= w_gnt1 ? num2_1 : num2_0;
        r_id  <= w_gnt1 ? ID1 : ID0;
        r_ptr <= w_gnt1 ? ID0 : ID1;
      end
      if (r_state == S_EXEC) begin
        r_resp_valid <= 1'b1;
        r_resp_id    <= r_id;
        r_result     <= w_result;
        r_bal        <= w_bal;
      end
      if (r_state == S_RESP && r_resp_valid && resp_ready) begin
        r_resp_valid <= 1'b0;
        if (r_cnt != {CNTW{1'b1}}) r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign ack0         = r_ack0;
  assign ack1         = r_ack1;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_result  = r_result;
  assign resp_balance = r_bal;
  assign busy         = (r_state != S_IDLE);
  assign op_count     = r_cnt;

endmodule

// File: doc/bitcount_arbiter.md
Name: bitcount_arbiter

Overview:
Shares one 5-bit one-bit-count datapath between two requesters.
- Round-robin arbitration, operand capture and a 1-cycle compute stage.
- Registered response buffer with valid/ready handshake.
- Saturating count of completed operations.
- Sits between the ALU operation decoder (requesters) and the result writeback path.

Parameters:
OPW, 5, operand width per number.
RESW, 32, result width (sign-style extension of the 4-bit count).
CNTW, 16, width of the completed-operation counter.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
req0  in  1  requester 0 request; held high until ack0.
num1_0  in  OPW  requester 0 first operand.
num2_0  in  OPW  requester 0 second operand.
ack0  out  1  one-cycle pulse: requester 0 operands captured.
req1, num1_1, num2_1, ack1  same as above, for requester 1.
resp_valid  out  1  response buffer holds a result.
resp_ready  in  1  consumer accepts the response.
resp_id  out  1  requester that owns the response.
resp_result  out  RESW  extended count.
resp_balance  out  1  parity flag of the count.
busy  out  1  high in any state other than IDLE.
op_count  out  CNTW  completed responses, saturating.

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high; it is sampled on the rising edge of `clk`.
- Reset:
  - State goes to IDLE and the priority pointer to requester 0.
  - All outputs go to 0: ack0/1, resp_valid, resp_id, resp_result, resp_balance, busy, op_count.
  - Reset mid-operation (EXEC or RESP) discards the in-flight op; no ack or response is emitted for it afterwards.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the pointer's requester.
  - On grant: latch both operands and the id, pulse the granted ack (registered, high during the first EXEC cycle), toggle the pointer to the non-granted requester, go to EXEC.
  - With no request, stay in IDLE.
- EXEC (exactly 1 cycle):
  - Core computes from the latched operands. resp_result, resp_balance and resp_id are registered at the end of the cycle.
  - resp_valid is set; go to RESP.
- RESP:
  - Hold all resp_* stable while resp_ready is low.
  - On resp_valid && resp_ready: clear resp_valid, increment op_count (saturate at all-ones), go to IDLE.
  - req inputs are ignored in EXEC and RESP.
- Latency and throughput:
  - A req sampled at edge N gives ack at N+1 and resp_valid from N+2.
  - With resp_ready held high, one op completes every 3 cycles.
- Requester rule: drop or refresh req after ack. A req still high when IDLE is next re-entered is a new request.
- Arithmetic:
  - calc (4 bits) = popcount(num1) + popcount(num2); range 0..10.
  - resp_balance = 1 iff popcount(calc) is even.
  - resp_result = {28 copies of calc[3], calc}, so counts of 8..10 read back with the upper bits set. This is required for compatibility with the existing writeback.
- Fairness: with both reqs continuously high, grants alternate 0,1,0,1.

Decomposition:
- Shared package holds:
  - OPW, RESW, CNTW defaults.
  - FSM state encoding (IDLE=0, EXEC=1, RESP=2).
  - Requester-id constants.
- One sub-module: bitcount_core. It is combinational: two OPW operands in; calc[3:0], balance and the extended result out.

Test Plan:
- Reset, then req0 with num1_0=00001, num2_0=00000: ack0 one cycle later; resp_valid after 2 cycles, resp_result=0x00000001, balance=0, id=0.
- req1 with 00011/00001, resp_ready=1: calc=3, result=0x00000003, balance=1, id=1, op_count increments by 1.
- req0 with 11111/11111: calc=10, result=0xFFFFFFFA, balance=1.
- req0 and req1 held high together from reset, resp_ready=1: grant order 0,1,0,1; each ack is a single-cycle pulse; one response every 3 cycles.
- resp_ready=0 for 5 cycles in RESP: all resp_* stable, busy=1, no new ack despite req high. Raise resp_ready: completes, next grant follows.
- Assert reset during EXEC: next cycle state is IDLE, resp_valid=0, op_count=0, pointer=0; no stale response appears afterwards.
